lmem_arbiter: RTL and testbench
===============================

# lmem_arbiter

Arbitrates the shared layer-buffer memory port (csel/cwr/crd interface, banks L0 and L1) among three requesters: the convolution writer (port 0), the max-pool reader (port 1) and the host readback/DMA port (port 2). Grants one access per cycle, round-robin with bounded burst locking. Drives the memory strobes from registers and routes read data back with a fixed latency. Sits between the ATCONV-style compute engines and the layer memory model.

## Interface
- AW, 12, memory address width (4096 words per bank)
- DW, 13, data width (signed fixed-point words)
- LOCK_MAX, 4, max consecutive locked beats per grant (range 1..15)
- clk  in  1  clock, all logic on rising edge
- reset  in  1  reset, synchronous, active-high
- req  in  3  per-port access request
- we  in  3  per-port 1 = write, 0 = read
- sel  in  3  per-port bank select (0 = L0, 1 = L1)
- lock  in  3  per-port request to keep grant for next beat
- addr  in  3*AW  per-port address, port i at [i*AW +: AW]
- wdata  in  3*DW  per-port write data, port i at [i*DW +: DW]
- gnt  out  3  one-hot grant, combinational from state and req
- rvalid  out  3  one-cycle read-data-valid per port, registered
- rdata  out  DW  read data, equals cdata_rd
- csel  out  1  memory bank select, registered
- cwr  out  1  memory write strobe, registered
- caddr_wr  out  AW  memory write address, registered
- cdata_wr  out  DW  memory write data, registered
- crd  out  1  memory read strobe, registered
- caddr_rd  out  AW  memory read address, registered
- cdata_rd  in  DW  memory read data, valid the cycle after crd

## Operation
- Handshake: a beat transfers on a rising edge where req[i] & gnt[i]. gnt is one-hot or zero, and never asserted to a port with req low.
- Round-robin pointer `last` (2 bits, reset = 2): search order starts at last+1 mod 3. On each transfer, `last` is set to the granted port unless the beat continues a lock.
- States:
  - IDLE: no grant holder. Any req moves to GRANT.
  - GRANT: the beat transfers. If lock[g] & req[g] and beat_cnt < LOCK_MAX-1, go to LOCKED with beat_cnt+1. Otherwise stay in GRANT (next arbitration) if any req, else go to IDLE.
  - LOCKED: gnt forced to holder g while req[g] is high. req[g] low returns to IDLE/GRANT arbitration in the same cycle (no dead cycle). When beat_cnt reaches LOCK_MAX-1, that beat is the last; beat_cnt clears and the next grant rotates past g.
- Memory drive, cycle after a transfer:
  - Write: cwr=1, caddr_wr=addr, cdata_wr=wdata, crd=0.
  - Read: crd=1, caddr_rd=addr, cwr=0.
  - In both cases csel=sel of the granted port.
  - With no transfer, cwr=crd=0 and addresses, data and csel hold their values.
- Read return: a 2-entry tag pipe carries the port id. rvalid[id] pulses exactly 2 cycles after the handshake edge. rdata = cdata_rd.
- Ordering: single in-order pipe. A write followed by a read of the same address on the next beat returns the new data.

## Timing
- Reset values:
  - gnt=0, rvalid=0, cwr=0, crd=0, csel=0, caddr_wr=0, caddr_rd=0, cdata_wr=0.
  - State IDLE, last=2, beat_cnt=0.
- Reset asserted mid-operation: in-flight reads are dropped (no rvalid after reset) and locks are released.
- Throughput is 1 beat/cycle, with back-to-back grants across ports and no bubble.
- Memory strobe latency is 1 cycle after the handshake. Read data latency is 2 cycles.
- When all three ports request in the same cycle after reset, grant order is 0, 1, 2, 0, …
- Starvation bound: any requesting port is granted within 2*LOCK_MAX beats.

## Test plan
- **Reset, then simultaneous requests.** After reset, req=3'b111 with all reads for 6 cycles. Required: gnt sequence 001, 010, 100, 001, 010, 100. rvalid pulses 2 cycles later in the same order. crd stays high continuously.
- **Single write then read.** Port 0 writes addr 12'h040 with data 13'h0123 on sel=0. Port 1 then reads 12'h040 on the next beat. Required: cwr=1 with caddr_wr=040 and cdata_wr=0123 in the cycle after the write. rvalid[1]=1 with rdata=0123.
- **Lock bounded by LOCK_MAX=4.** Port 1 holds req and lock for 8 beats while port 2 requests continuously. Required: port 1 granted 4 beats, port 2 granted 1, then port 1 granted 4 again.
- **Early lock release.** Port 1 locks, then drops req after 2 beats while port 0 is waiting. Required: port 0 is granted in the very next cycle, with no idle cycle on cwr/crd.
- **Reset mid-read.** Port 2 read accepted; reset is asserted on the following edge. Required: rvalid stays 0, all strobes are 0, and `last` returns to 2.
- **Bank select.** Port 2 writes with sel=1 to addr 12'h3FF. Required: csel=1 and cwr=1 in the cycle after the write. With no further requests, csel holds 1 and cwr falls to 0.

Source files
------------

// File: rtl/lmem_arbiter.sv
// lmem_arbiter: shares the layer-buffer memory port (csel/cwr/crd) among the
// convolution writer (port 0), max-pool reader (port 1) and host/DMA port
// (port 2). One beat per cycle, round-robin with bounded lock bursts, strobes
// driven from registers, read data tagged back to its port two cycles later.
module lmem_arbiter #(
  parameter int AW       = 12,
  parameter int DW       = 13,
  parameter int LOCK_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        req,
  input  logic [2:0]        we,
  input  logic [2:0]        sel,
  input  logic [2:0]        lock,
  input  logic [3*AW-1:0]   addr,
  input  logic [3*DW-1:0]   wdata,
  output logic [2:0]        gnt,
  output logic [2:0]        rvalid,
  output logic [DW-1:0]     rdata,
  output logic              csel,
  output logic              cwr,
  output logic [AW-1:0]     caddr_wr,
  output logic [DW-1:0]     cdata_wr,
  output logic              crd,
  output logic [AW-1:0]     caddr_rd,
  input  logic [DW-1:0]     cdata_rd
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // Index of the final beat a single lock burst may take.
  localparam logic [3:0] LAST_BEAT = 4'(LOCK_MAX - 1);

  state_t     state;
  state_t     state_nx;
  logic [1:0] last;
  logic [1:0] last_nx;
  logic [1:0] holder;
  logic [1:0] holder_nx;
  logic [3:0] beat_cnt;
  logic [3:0] beat_cnt_nx;

  logic [1:0] rr_first;
  logic [1:0] rr_second;
  logic [1:0] rr_third;
  logic [1:0] rr_port;
  logic       rr_hit;

  logic       holding;
  logic       xfer;
  logic [1:0] gport;
  logic [3:0] run_cnt;

  logic       rd_pend;
  logic [1:0] rd_id;

  // Successor of a port in the 0 -> 1 -> 2 -> 0 rotation.
  function automatic logic [1:0] next_port(input logic [1:0] p);
    case (p)
      2'd0:    next_port = 2'd1;
      2'd1:    next_port = 2'd2;
      default: next_port = 2'd0;
    endcase
  endfunction

  // Round-robin candidate: first requester searching from last+1 mod 3.
  always_comb begin
    rr_first  = next_port(last);
    rr_second = next_port(rr_first);
    rr_third  = next_port(rr_second);
    rr_port   = 2'd0;
    rr_hit    = 1'b0;
    if (req[rr_first]) begin
      rr_port = rr_first;
      rr_hit  = 1'b1;
    end else if (req[rr_second]) begin
      rr_port = rr_second;
      rr_hit  = 1'b1;
    end else if (req[rr_third]) begin
      rr_port = rr_third;
      rr_hit  = 1'b1;
    end else begin
      rr_port = 2'd0;
      rr_hit  = 1'b0;
    end
  end

  // Beat owner: a live lock keeps the holder, a dropped lock falls straight
  // through to round-robin in the same cycle so no beat is lost.
  always_comb begin
    holding = (state == LOCKED) && req[holder];
    if (holding) begin
      gport   = holder;
      run_cnt = beat_cnt;
      xfer    = 1'b1;
    end else begin
      gport   = rr_port;
      run_cnt = 4'd0;
      xfer    = rr_hit;
    end
  end

  // State register: arbitration state, rotation pointer and lock bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      last     <= 2'd2;
      holder   <= 2'd0;
      beat_cnt <= 4'd0;
    end else begin
      state    <= state_nx;
      last     <= last_nx;
      holder   <= holder_nx;
      beat_cnt <= beat_cnt_nx;
    end
  end

  // Next state: a locked beat below the burst limit extends the lock,
  // anything else returns to open arbitration.
  always_comb begin
    state_nx    = state;
    last_nx     = last;
    holder_nx   = holder;
    beat_cnt_nx = beat_cnt;
    if (xfer) begin
      last_nx = gport;
      if (lock[gport] && (run_cnt < LAST_BEAT)) begin
        state_nx    = LOCKED;
        holder_nx   = gport;
        beat_cnt_nx = run_cnt + 4'd1;
      end else begin
        state_nx    = GRANT;
        holder_nx   = holder;
        beat_cnt_nx = 4'd0;
      end
    end else begin
      state_nx    = IDLE;
      beat_cnt_nx = 4'd0;
    end
  end

  // Grant output: one-hot to the beat owner, zero when nobody transfers.
  always_comb begin
    if (xfer) begin
      gnt = 3'b001 << gport;
    end else begin
      gnt = 3'b000;
    end
  end

  // Memory strobes and address/data, loaded on the edge that takes the beat;
  // address, data and bank hold when idle so the memory sees stable values.
  always_ff @(posedge clk) begin
    if (reset) begin
      csel     <= 1'b0;
      cwr      <= 1'b0;
      crd      <= 1'b0;
      caddr_wr <= {AW{1'b0}};
      cdata_wr <= {DW{1'b0}};
      caddr_rd <= {AW{1'b0}};
    end else if (xfer) begin
      csel <= sel[gport];
      if (we[gport]) begin
        cwr      <= 1'b1;
        crd      <= 1'b0;
        caddr_wr <= addr[gport*AW +: AW];
        cdata_wr <= wdata[gport*DW +: DW];
      end else begin
        cwr      <= 1'b0;
        crd      <= 1'b1;
        caddr_rd <= addr[gport*AW +: AW];
      end
    end else begin
      cwr <= 1'b0;
      crd <= 1'b0;
    end
  end

  // Read tag pipe: first stage rides with crd, second stage is rvalid and
  // lines up with cdata_rd. Reset flushes both, dropping in-flight reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pend <= 1'b0;
      rd_id   <= 2'd0;
      rvalid  <= 3'b000;
    end else begin
      rd_pend <= xfer & ~we[gport];
      rd_id   <= gport;
      rvalid  <= rd_pend ? (3'b001 << rd_id) : 3'b000;
    end
  end

  assign rdata = cdata_rd;

endmodule

// File: tb/tb_lmem_arbiter.sv
// Bench for lmem_arbiter: reset/simultaneous-request table, hand sequences
// for write-read ordering, lock bounds, early release, reset mid-read and
// bank select, then random traffic against a behavioural arbitration model.
module tb_lmem_arbiter;
  localparam int AW       = 12;
  localparam int DW       = 13;
  localparam int LOCK_MAX = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [2:0]      req, we, sel, lock;
  logic [3*AW-1:0] addr;
  logic [3*DW-1:0] wdata;
  logic [2:0]      gnt, rvalid;
  logic [DW-1:0]   rdata;
  logic            csel, cwr, crd;
  logic [AW-1:0]   caddr_wr, caddr_rd;
  logic [DW-1:0]   cdata_wr;
  logic [DW-1:0]   cdata_rd = '0;

  int total = 0;
  int bad   = 0;

  lmem_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .sel(sel), .lock(lock),
    .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .csel(csel), .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
    .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd)
  );

  always #5 clk = ~clk;

  // Layer memory: write on cwr, read data registered one cycle after crd.
  logic [DW-1:0] env_mem [0:1][0:4095];
  always @(posedge clk) begin
    if (cwr) env_mem[csel][caddr_wr] <= cdata_wr;
    if (crd) cdata_rd <= env_mem[csel][caddr_rd];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    req = 3'b000; we = 3'b000; sel = 3'b000; lock = 3'b000;
    addr = '0; wdata = '0;
  endtask

  task automatic set_port(input int p, input logic r, input logic w, input logic s,
                          input logic l, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[p] = r; we[p] = w; sel[p] = s; lock[p] = l;
    addr[p*AW +: AW]  = a;
    wdata[p*DW +: DW] = d;
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  typedef struct {
    logic [2:0] req;
    logic [2:0] exp_gnt;
    logic       exp_crd;
    logic [2:0] exp_rv;
  } vec_t;
  vec_t tbl [9];

  // Behavioural arbitration model: rotation pointer, lock holder, burst length.
  int m_last, m_holder, m_run;
  logic [DW-1:0] ref_mem [0:1][0:7];
  bit            ref_wr  [0:1][0:7];

  function automatic int model_pick(input logic [2:0] r, input int lst, input int hold);
    if (hold >= 0 && r[hold]) return hold;
    for (int off = 1; off <= 3; off++) begin
      if (r[(lst + off) % 3]) return (lst + off) % 3;
    end
    return -1;
  endfunction

  logic          e_cwr, e_crd, e_csel;
  logic [AW-1:0] e_awr, e_ard;
  logic [DW-1:0] e_dwr;
  bit            p1v, p2v, p1k, p2k;
  int            p1id, p2id;
  logic [DW-1:0] p1d, p2d;
  logic [2:0]    e_gnt, e_rv;
  int            g, p1cnt;
  int            lock_seq [9];

  initial begin
    clear_inputs();
    do_reset();

    // Reset values.
    #4;
    chk("rst_gnt", gnt, 3'b000);       chk("rst_rvalid", rvalid, 3'b000);
    chk("rst_cwr", cwr, 1'b0);         chk("rst_crd", crd, 1'b0);
    chk("rst_csel", csel, 1'b0);       chk("rst_caddr_wr", caddr_wr, 12'h000);
    chk("rst_caddr_rd", caddr_rd, 12'h000); chk("rst_cdata_wr", cdata_wr, 13'h0000);
    tick();

    // All three ports read together for six cycles.
    tbl[0] = '{req:3'b111, exp_gnt:3'b001, exp_crd:1'b0, exp_rv:3'b000};
    tbl[1] = '{req:3'b111, exp_gnt:3'b010, exp_crd:1'b1, exp_rv:3'b000};
    tbl[2] = '{req:3'b111, exp_gnt:3'b100, exp_crd:1'b1, exp_rv:3'b001};
    tbl[3] = '{req:3'b111, exp_gnt:3'b001, exp_crd:1'b1, exp_rv:3'b010};
    tbl[4] = '{req:3'b111, exp_gnt:3'b010, exp_crd:1'b1, exp_rv:3'b100};
    tbl[5] = '{req:3'b111, exp_gnt:3'b100, exp_crd:1'b1, exp_rv:3'b001};
    tbl[6] = '{req:3'b000, exp_gnt:3'b000, exp_crd:1'b1, exp_rv:3'b010};
    tbl[7] = '{req:3'b000, exp_gnt:3'b000, exp_crd:1'b0, exp_rv:3'b100};
    tbl[8] = '{req:3'b000, exp_gnt:3'b000, exp_crd:1'b0, exp_rv:3'b000};
    for (int i = 0; i < 9; i++) begin
      clear_inputs();
      req = tbl[i].req;
      #4;
      chk("tbl_gnt", gnt, tbl[i].exp_gnt);
      chk("tbl_crd", crd, tbl[i].exp_crd);
      chk("tbl_rvalid", rvalid, tbl[i].exp_rv);
      tick();
    end

    // Write on port 0 then read of the same address on port 1.
    do_reset();
    set_port(0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h040, 13'h0123);
    #4; chk("wr_gnt", gnt, 3'b001); tick();
    clear_inputs();
    set_port(1, 1'b1, 1'b0, 1'b0, 1'b0, 12'h040, 13'h0000);
    #4;
    chk("rd_gnt", gnt, 3'b010);        chk("wr_cwr", cwr, 1'b1);
    chk("wr_caddr", caddr_wr, 12'h040); chk("wr_cdata", cdata_wr, 13'h0123);
    chk("wr_csel", csel, 1'b0);        chk("wr_crd", crd, 1'b0);
    tick();
    clear_inputs();
    #4;
    chk("rd_crd", crd, 1'b1); chk("rd_caddr", caddr_rd, 12'h040); chk("rd_cwr", cwr, 1'b0);
    tick();
    #4;
    chk("rd_rvalid", rvalid, 3'b010); chk("rd_rdata", rdata, 13'h0123);
    tick();

    // Port 1 locks for 8 beats against continuous port 2 traffic.
    do_reset();
    lock_seq = '{1, 1, 1, 1, 2, 1, 1, 1, 1};
    p1cnt = 0;
    for (int i = 0; i < 9; i++) begin
      clear_inputs();
      set_port(1, (p1cnt < 8) ? 1'b1 : 1'b0, 1'b0, 1'b0, 1'b1, 12'h010, 13'h0000);
      set_port(2, 1'b1, 1'b0, 1'b0, 1'b0, 12'h020, 13'h0000);
      #4;
      chk("lock_gnt", gnt, 3'b001 << lock_seq[i]);
      if (gnt[1]) p1cnt++;
      tick();
    end

    // Port 1 lock released early while port 0 waits.
    do_reset();
    set_port(1, 1'b1, 1'b1, 1'b0, 1'b1, 12'h011, 13'h0011);
    #4; chk("rel_gnt0", gnt, 3'b010); tick();
    set_port(0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h012, 13'h0000);
    #4; chk("rel_gnt1", gnt, 3'b010); chk("rel_cwr1", cwr, 1'b1); tick();
    set_port(1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 13'h0000);
    #4; chk("rel_gnt2", gnt, 3'b001); chk("rel_cwr2", cwr, 1'b1); chk("rel_crd2", crd, 1'b0); tick();
    clear_inputs();
    #4; chk("rel_crd3", crd, 1'b1); chk("rel_cwr3", cwr, 1'b0); chk("rel_gnt3", gnt, 3'b000); tick();

    // Reset on the edge after a port 2 read is accepted.
    do_reset();
    set_port(2, 1'b1, 1'b0, 1'b0, 1'b0, 12'h055, 13'h0000);
    #4; chk("rmr_gnt", gnt, 3'b100); tick();
    reset = 1'b1;
    clear_inputs();
    #4; chk("rmr_rv0", rvalid, 3'b000);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #4;
      chk("rmr_rvalid", rvalid, 3'b000); chk("rmr_crd", crd, 1'b0); chk("rmr_cwr", cwr, 1'b0);
      tick();
    end
    req = 3'b111;
    #4; chk("rmr_last", gnt, 3'b001); tick();
    clear_inputs();

    // Bank select on a port 2 write.
    do_reset();
    set_port(2, 1'b1, 1'b1, 1'b1, 1'b0, 12'h3FF, 13'h0AAA);
    #4; chk("bank_gnt", gnt, 3'b100); tick();
    clear_inputs();
    #4; chk("bank_csel1", csel, 1'b1); chk("bank_cwr1", cwr, 1'b1); chk("bank_addr", caddr_wr, 12'h3FF); tick();
    #4; chk("bank_csel2", csel, 1'b1); chk("bank_cwr2", cwr, 1'b0); tick();

    // Random traffic against the model.
    do_reset();
    m_last = 2; m_holder = -1; m_run = 0;
    e_cwr = 1'b0; e_crd = 1'b0; e_csel = 1'b0; e_awr = '0; e_ard = '0; e_dwr = '0;
    p1v = 0; p2v = 0; p1k = 0; p2k = 0; p1id = 0; p2id = 0; p1d = '0; p2d = '0;
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 8; a++) begin ref_wr[b][a] = 0; ref_mem[b][a] = '0; end
    for (int c = 0; c < 600; c++) begin
      for (int p = 0; p < 3; p++)
        set_port(p, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) != 0), 12'($urandom_range(0, 7)), 13'($urandom_range(0, 8191)));
      #4;
      g = model_pick(req, m_last, m_holder);
      e_gnt = (g < 0) ? 3'b000 : (3'b001 << g);
      e_rv  = p2v ? (3'b001 << p2id) : 3'b000;
      chk("rnd_gnt", gnt, e_gnt);
      chk("rnd_rvalid", rvalid, e_rv);
      if (p2v && p2k) chk("rnd_rdata", rdata, p2d);
      chk("rnd_cwr", cwr, e_cwr);  chk("rnd_crd", crd, e_crd);  chk("rnd_csel", csel, e_csel);
      chk("rnd_caddr_wr", caddr_wr, e_awr); chk("rnd_cdata_wr", cdata_wr, e_dwr);
      chk("rnd_caddr_rd", caddr_rd, e_ard);
      // Advance model by one cycle.
      p2v = p1v; p2k = p1k; p2id = p1id; p2d = p1d;
      p1v = 0; p1k = 0;
      if (m_holder >= 0 && !req[m_holder]) begin m_holder = -1; m_run = 0; end
      if (g >= 0) begin
        int run_n, a;
        int b;
        a = int'(addr[g*AW +: AW]);
        b = int'(sel[g]);
        e_csel = sel[g];
        if (we[g]) begin
          e_cwr = 1'b1; e_crd = 1'b0;
          e_awr = addr[g*AW +: AW]; e_dwr = wdata[g*DW +: DW];
          ref_mem[b][a] = wdata[g*DW +: DW]; ref_wr[b][a] = 1;
        end else begin
          e_cwr = 1'b0; e_crd = 1'b1;
          e_ard = addr[g*AW +: AW];
          p1v = 1; p1id = g; p1d = ref_mem[b][a]; p1k = ref_wr[b][a];
        end
        run_n = (m_holder == g) ? m_run + 1 : 1;
        if (lock[g] && run_n < LOCK_MAX) begin m_holder = g; m_run = run_n; end
        else begin m_holder = -1; m_run = 0; end
        m_last = g;
      end else begin
        e_cwr = 1'b0; e_crd = 1'b0;
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
